// File: rtl/mux_nx1_scan.sv
// N-channel, W-bit registered multiplexer with valid flag, clock enable and an
// auto-scan mode that holds each channel for a programmable number of enabled edges.
module mux_nx1_scan #(
  parameter int unsigned W     = 4,
  parameter int unsigned N     = 8,
  parameter int unsigned SW    = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  i,
  input  logic [SW-1:0]   s,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    f,
  output logic [SW-1:0]   ch,
  output logic            valid,
  output logic            wrap,
  output logic            err
);

  localparam int unsigned DCW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    AUTO = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    ch_q, ch_d;
  logic [DCW-1:0]   dwell_q, dwell_d;
  logic [W-1:0]     f_q, f_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             s_ok;

  // Widened compare so N == 2**SW is handled without overflow.
  assign s_ok = (32'(s) < N);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;
    f_d     = f_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (en) begin
      valid_d = 1'b1;
      state_d = mode ? AUTO : MAN;

      if (!mode) begin
        dwell_d = '0;
        if (s_ok) begin
          ch_d = s;
        end else begin
          err_d = 1'b1;
        end
      end else if (state_q != AUTO) begin
        // Load edge into auto: restart the dwell on the current channel.
        dwell_d = '0;
      end else if (dwell_q == DCW'(DWELL - 1)) begin
        dwell_d = '0;
        if (ch_q == SW'(N - 1)) begin
          ch_d   = '0;
          wrap_d = 1'b1;
        end else begin
          ch_d = ch_q + SW'(1);
        end
      end else begin
        dwell_d = dwell_q + DCW'(1);
      end

      // Only legal channels are decoded; f always matches the ch being registered.
      f_d = '0;
      for (int k = 0; k < N; k++) begin
        if (ch_d == SW'(k)) begin
          f_d = i[k*W +: W];
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dwell_q <= '0;
      f_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      f_q     <= f_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign f     = f_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule
